// File: rtl/switch_port_mc_pkg.sv
// Shared types and the head-packet classifier for the switch ingress port.
package switch_port_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROUTE,
    ARB_WAIT,
    DONE,
    DONE_TO
  } port_state_t;

  typedef enum logic [1:0] {
    ERR,
    SDP,
    MDP,
    BDP
  } pkt_type_t;

  // Widest supported switch; narrower ports zero-extend into this width.
  localparam int MAX_PORTS = 8;

  // Classify a packet from its source and target masks. Only the low
  // n_ports bits are considered.
  function automatic pkt_type_t classify(input logic [MAX_PORTS-1:0] src,
                                         input logic [MAX_PORTS-1:0] tgt,
                                         input int n_ports);
    logic [MAX_PORTS-1:0] mask;
    pkt_type_t t;
    mask = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n_ports) mask[i] = 1'b1;
    end
    if ($countones(src & mask) != 1 || (tgt & mask) == '0) t = ERR;
    else if ((tgt & mask) == mask) t = BDP;
    else if ((tgt & src & mask) != '0) t = ERR;
    else if ($countones(tgt & mask) == 1) t = SDP;
    else t = MDP;
    return t;
  endfunction

endpackage

// File: rtl/switch_port_mc_fifo.sv
// Ingress packet FIFO: registered pointers with a wrap bit, combinational head.
module pkt_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];

  // Pointer update; writes while full and reads while empty are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/switch_port_mc.sv
// Ingress port: buffers packets, requests target egresses, tracks partial
// multicast delivery, times out stuck packets and keeps saturating stats.
//
//   state    | meaning
//   IDLE     | waiting for a packet at the FIFO head
//   ROUTE    | head latched; classify and load the pending mask
//   ARB_WAIT | requesting pending egresses, retiring granted ones
//   DONE     | all targets served; pop and count delivery
//   DONE_TO  | wait budget exhausted; pop and count timeout
module switch_port_mc
  import switch_port_mc_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [N_PORTS-1:0] source_in,
  input  logic [N_PORTS-1:0] target_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [N_PORTS-1:0] grant_in,
  output logic [N_PORTS-1:0] req_out,
  output logic               pkt_valid_out,
  output logic [N_PORTS-1:0] dest_out,
  output logic [N_PORTS-1:0] source_out,
  output logic [N_PORTS-1:0] target_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic [CNT_W-1:0]   tx_cnt
);
  localparam int FW     = DATA_W + 2 * N_PORTS;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  port_state_t          state_q, state_d;
  logic [N_PORTS-1:0]   pending_q, pending_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [N_PORTS-1:0]   served;
  logic                 pop, inc_drop, inc_tx, inc_to;
  logic                 fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_head;
  logic [MAX_PORTS-1:0] src_ext, tgt_ext;
  pkt_type_t            head_type;

  assign ready_in = !fifo_full;

  pkt_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (valid_in && ready_in),
    .rd_en   (pop),
    .wr_data ({data_in, target_in, source_in}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign src_ext   = MAX_PORTS'(source_out);
  assign tgt_ext   = MAX_PORTS'(target_out);
  assign head_type = classify(src_ext, tgt_ext, N_PORTS);

  assign busy          = (state_q != IDLE);
  assign req_out       = (state_q == ARB_WAIT) ? pending_q : '0;
  assign dest_out      = served;
  assign pkt_valid_out = |served;

  // Latch the FIFO head as the FSM leaves IDLE; held until the next packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else if (state_q == IDLE && !fifo_empty) begin
      {data_out, target_out, source_out} <= fifo_head;
    end
  end

  // FSM state, pending mask and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state, delivery tracking and pop/statistic strobes.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wait_d    = wait_q;
    served    = '0;
    pop       = 1'b0;
    inc_drop  = 1'b0;
    inc_tx    = 1'b0;
    inc_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ROUTE;
      end
      ROUTE: begin
        if (head_type == ERR) begin
          pop      = 1'b1;
          inc_drop = 1'b1;
          state_d  = IDLE;
        end else begin
          // Broadcast targets include the source bit; never send back to self.
          pending_d = target_out & ~source_out;
          wait_d    = '0;
          state_d   = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        served    = grant_in & pending_q;
        pending_d = pending_q & ~served;
        if (pending_d == '0) state_d = DONE;
        else if (WAIT_MAX != 0 && wait_q == WAIT_LAST) state_d = DONE_TO;
        else wait_d = wait_q + 1'b1;
      end
      DONE: begin
        pop       = 1'b1;
        inc_tx    = 1'b1;
        pending_d = '0;
        state_d   = IDLE;
      end
      DONE_TO: begin
        pop       = 1'b1;
        inc_to    = 1'b1;
        pending_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt    <= '0;
      timeout_cnt <= '0;
      tx_cnt      <= '0;
    end else begin
      if (inc_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (inc_to && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
      if (inc_tx && tx_cnt != '1) tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_port_mc.sv
// Bench for switch_port_mc: directed table, randomized packets against a
// transaction-level model, and a fill/reset sequence.
module tb_switch_port_mc;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int WM = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [NP-1:0] source_in = '0;
  logic [NP-1:0] target_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [NP-1:0] grant_in = '0;
  logic [NP-1:0] req_out;
  logic          pkt_valid_out;
  logic [NP-1:0] dest_out;
  logic [NP-1:0] source_out;
  logic [NP-1:0] target_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] tx_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int m_tx = 0;
  int m_drop = 0;
  int m_to = 0;

  switch_port_mc #(.N_PORTS(NP), .DATA_W(DW), .DEPTH(8), .WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .grant_in(grant_in), .req_out(req_out), .pkt_valid_out(pkt_valid_out),
    .dest_out(dest_out), .source_out(source_out), .target_out(target_out),
    .data_out(data_out), .busy(busy), .drop_cnt(drop_cnt),
    .timeout_cnt(timeout_cnt), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, req_out, 0);
    chk({tag, "_pv"}, pkt_valid_out, 0);
    chk({tag, "_dest"}, dest_out, 0);
    chk({tag, "_src"}, source_out, 0);
    chk({tag, "_tgt"}, target_out, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnts"}, {drop_cnt, timeout_cnt} | tx_cnt, 0);
    chk({tag, "_ready"}, ready_in, 1);
  endtask

  // One packet through the port. dly[b] = ARB_WAIT cycle index at which
  // egress b is granted (>= WM means never). Expectations come from the
  // routing rules: which targets are owed, when each is served, how long
  // the port waits, and which statistic moves.
  task automatic run_pkt(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] data,
                         input logic [3:0][3:0] dly, output logic [3:0] req_any);
    bit err;
    logic [3:0] rem, sel;
    int maxd, arb, nb;
    err = ($countones(src) != 1) || (tgt == 0) || (tgt != 4'hF && (tgt & src) != 0);
    rem = err ? 4'h0 : ((tgt == 4'hF) ? (tgt & ~src) : tgt);
    maxd = 0;
    for (int b = 0; b < 4; b++) if (rem[b] && int'(dly[b]) > maxd) maxd = int'(dly[b]);
    if (err) arb = 0;
    else if (maxd < WM) arb = maxd + 1;
    else arb = WM;
    nb = err ? 1 : arb + 2;
    req_any = '0;

    @(negedge clk);
    chk("ready_in", ready_in, 1);
    valid_in = 1'b1; source_in = src; target_in = tgt; data_in = data;
    @(negedge clk);
    valid_in = 1'b0;
    #1 chk("busy_latency", busy, 0);
    for (int j = 0; j < nb; j++) begin
      bit in_arb;
      @(negedge clk);
      in_arb = !err && j >= 1 && j <= arb;
      sel = '0;
      if (in_arb) for (int b = 0; b < 4; b++) if (rem[b] && int'(dly[b]) == j - 1) sel[b] = 1'b1;
      grant_in = in_arb ? (sel | (4'($urandom) & ~rem)) : 4'($urandom);
      #1;
      chk("busy", busy, 1);
      chk("req_out", req_out, in_arb ? rem : 4'h0);
      chk("dest_out", dest_out, sel);
      chk("pkt_valid", pkt_valid_out, |sel);
      chk("head", {source_out, target_out, data_out}, {src, tgt, data});
      req_any |= req_out;
      rem &= ~sel;
    end
    @(negedge clk);
    grant_in = '0;
    #1;
    chk("busy_end", busy, 0);
    chk("hold_data", data_out, data);
    if (err) m_drop++;
    else if (maxd < WM) m_tx++;
    else m_to++;
    chk("tx_cnt", tx_cnt, m_tx);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("timeout_cnt", timeout_cnt, m_to);
  endtask

  typedef struct {
    logic [3:0]       src;
    logic [3:0]       tgt;
    logic [3:0][3:0]  dly;
    logic [3:0]       exp_req;
    int               exp_res; // 0 delivered, 1 dropped, 2 timed out
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0] req_any;
    logic [3:0] src, tgt;
    logic [3:0][3:0] dly;
    int b_tx, b_drop, b_to;
    bit found, seen_busy;

    // dly nibbles listed {egress3, egress2, egress1, egress0}
    tbl[0]  = '{4'b0001, 4'b0100, 16'hF0FF, 4'b0100, 0};
    tbl[1]  = '{4'b0001, 4'b1010, 16'h3F0F, 4'b1010, 0};
    tbl[2]  = '{4'b0010, 4'b1111, 16'h0000, 4'b1101, 0};
    tbl[3]  = '{4'b0011, 4'b0100, 16'h0000, 4'b0000, 1};
    tbl[4]  = '{4'b0001, 4'b0000, 16'h0000, 4'b0000, 1};
    tbl[5]  = '{4'b0001, 4'b0011, 16'h0000, 4'b0000, 1};
    tbl[6]  = '{4'b0001, 4'b0100, 16'hFFFF, 4'b0100, 2};
    tbl[7]  = '{4'b1000, 4'b0001, 16'hFFF0, 4'b0001, 0};
    tbl[8]  = '{4'b0000, 4'b0100, 16'h0000, 4'b0000, 1};
    tbl[9]  = '{4'b0100, 4'b0100, 16'h0000, 4'b0000, 1};
    tbl[10] = '{4'b0100, 4'b1111, 16'h2F27, 4'b1011, 0};
    tbl[11] = '{4'b1000, 4'b0111, 16'hF180, 4'b0111, 2};

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk_all_zero("post_reset");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      b_tx = int'(tx_cnt); b_drop = int'(drop_cnt); b_to = int'(timeout_cnt);
      run_pkt(tbl[i].src, tbl[i].tgt, 8'h10 + 8'(i), tbl[i].dly, req_any);
      chk("tbl_req", req_any, tbl[i].exp_req);
      chk("tbl_result",
          {int'(timeout_cnt) - b_to == 1, int'(drop_cnt) - b_drop == 1, int'(tx_cnt) - b_tx == 1},
          3'b001 << tbl[i].exp_res);
    end

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) < 6) src = 4'b0001 << $urandom_range(0, 3);
      else src = 4'($urandom);
      tgt = 4'($urandom);
      for (int b = 0; b < 4; b++) dly[b] = 4'($urandom_range(0, 9));
      run_pkt(src, tgt, 8'($urandom), dly, req_any);
    end

    // Fill the FIFO with 9 back-to-back writes; the 9th must be refused.
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0100; data_in = 8'hA0 + 8'(i);
      #1 chk("fill_ready", ready_in, (i == 8) ? 1'b0 : 1'b1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    // Drain in order; reset in the middle of the 8th packet's ARB_WAIT.
    for (int p = 0; p < 8; p++) begin
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
        #1;
        if (req_out != 0) found = 1'b1;
        else @(negedge clk);
      end
      chk("fill_found", found, 1);
      chk("fill_order", data_out, 8'hA0 + 8'(p));
      chk("fill_req", req_out, 4'b0100);
      if (p < 7) begin
        grant_in = 4'b0100;
        @(negedge clk);
        grant_in = '0;
        @(negedge clk);
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_arb", req_out, 4'b0100);
    rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    chk("fifo_flushed", seen_busy, 0);
    chk("flushed_ready", ready_in, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
